// File: rtl/dram_access_sequencer.sv
// Converts byte/half/word loads and stores from the MMU DRAM port into aligned
// 32-bit accesses on a word-only memory; sub-word stores are read-modify-write.
module dram_access_sequencer #(
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] i_dram_addr,
  input  logic [31:0] i_dram_wdata,
  input  logic [2:0]  i_dram_ctrl,
  input  logic        i_dram_le,
  input  logic        i_dram_we_t,
  output logic [31:0] o_dram_odata,
  output logic        o_dram_busy,
  output logic        o_dram_err,
  output logic [31:0] mem_addr,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CMD, S_RD_WAIT, S_WR_CMD, S_MISAL, S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] odata_q, mem_addr_q, mem_wdata_q;
  logic        busy_q, err_q, cmd_valid_q, we_q;
  logic [1:0]  addr_lo_q, size_q;
  logic        uns_q, store_q;
  logic [15:0] wdata_q;
  logic [TW-1:0] wdog_q;

  logic        accept_d, misal_d, wd_expire_d;
  logic [4:0]  byte_shamt_d, half_shamt_d;
  logic [31:0] rd_byte_d, rd_half_d, load_d;
  logic [3:0]  be_d;
  logic [31:0] wrep_d, merge_d;

  assign accept_d = ((state_q == S_IDLE) || (state_q == S_DONE)) && (i_dram_le || i_dram_we_t);
  assign misal_d  = (i_dram_ctrl[1:0] == 2'b11) ||
                    ((i_dram_ctrl[1:0] == 2'b01) && i_dram_addr[0]) ||
                    ((i_dram_ctrl[1:0] == 2'b10) && (i_dram_addr[1:0] != 2'b00));
  assign wd_expire_d = (MEM_TIMEOUT != 0) && (wdog_q == TW'(MEM_TIMEOUT - 1));

  assign byte_shamt_d = {addr_lo_q, 3'b000};
  assign half_shamt_d = {addr_lo_q[1], 4'b0000};
  assign rd_byte_d    = mem_rdata >> byte_shamt_d;
  assign rd_half_d    = mem_rdata >> half_shamt_d;

  always_comb begin
    case (size_q)
      2'b00:   load_d = {{24{~uns_q & rd_byte_d[7]}}, rd_byte_d[7:0]};
      2'b01:   load_d = {{16{~uns_q & rd_half_d[15]}}, rd_half_d[15:0]};
      default: load_d = mem_rdata;
    endcase
  end

  // Store data is replicated across all lanes; the byte enables pick which lanes replace rdata.
  always_comb begin
    if (size_q == 2'b00) begin
      be_d   = 4'b0001 << addr_lo_q;
      wrep_d = {4{wdata_q[7:0]}};
    end else begin
      be_d   = addr_lo_q[1] ? 4'b1100 : 4'b0011;
      wrep_d = {2{wdata_q}};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merge_d[8*gi +: 8] = be_d[gi] ? wrep_d[8*gi +: 8] : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      odata_q     <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      addr_lo_q   <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      store_q     <= 1'b0;
      wdata_q     <= '0;
      wdog_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (accept_d) begin
            addr_lo_q  <= i_dram_addr[1:0];
            size_q     <= i_dram_ctrl[1:0];
            uns_q      <= i_dram_ctrl[2];
            store_q    <= i_dram_we_t;
            wdata_q    <= i_dram_wdata[15:0];
            mem_addr_q <= {i_dram_addr[31:2], 2'b00};
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            wdog_q     <= '0;
            if (misal_d) begin
              state_q <= S_MISAL;
              err_q   <= 1'b1;
              odata_q <= '0;
            end else if (i_dram_we_t && (i_dram_ctrl[1:0] == 2'b10)) begin
              // Full-word store needs no read: write straight through.
              state_q     <= S_WR_CMD;
              cmd_valid_q <= 1'b1;
              we_q        <= 1'b1;
              mem_wdata_q <= i_dram_wdata;
            end else begin
              state_q     <= S_RD_CMD;
              cmd_valid_q <= 1'b1;
              we_q        <= 1'b0;
            end
          end
        end
        S_MISAL: begin
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_RD_CMD: begin
          if (mem_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            wdog_q      <= '0;
            state_q     <= S_RD_WAIT;
          end else if (wd_expire_d) begin
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            wdog_q <= wdog_q + TW'(1);
          end
        end
        S_RD_WAIT: begin
          if (mem_rvalid) begin
            wdog_q <= '0;
            if (store_q) begin
              state_q     <= S_WR_CMD;
              cmd_valid_q <= 1'b1;
              we_q        <= 1'b1;
              mem_wdata_q <= merge_d;
            end else begin
              odata_q <= load_d;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
          end else if (wd_expire_d) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wdog_q <= wdog_q + TW'(1);
          end
        end
        S_WR_CMD: begin
          if (mem_cmd_ready || wd_expire_d) begin
            cmd_valid_q <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= ~mem_cmd_ready;
            state_q     <= S_DONE;
          end else begin
            wdog_q <= wdog_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_dram_odata  = odata_q;
  assign o_dram_busy   = busy_q;
  assign o_dram_err    = err_q;
  assign mem_addr      = mem_addr_q;
  assign mem_cmd_valid = cmd_valid_q;
  assign mem_we        = we_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_dram_access_sequencer.sv
// Directed bench for dram_access_sequencer: small word memory with
// controllable ready/rvalid, hand-computed expected results per access.
module tb_dram_access_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] i_dram_addr, i_dram_wdata;
  logic [2:0]  i_dram_ctrl;
  logic        i_dram_le, i_dram_we_t;
  logic [31:0] o_dram_odata;
  logic        o_dram_busy, o_dram_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_cmd_valid, mem_cmd_ready, mem_we, mem_rvalid;

  logic        ready_en, rv_en, inj_rv, rv_q;
  logic [31:0] mem_word;
  int          n_rd, n_wr, n_valid;
  logic [31:0] rd_addr, wr_addr, wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, rd0, wr0, v0;

  always #5 CLK = ~CLK;

  dram_access_sequencer #(.MEM_TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .i_dram_addr(i_dram_addr), .i_dram_wdata(i_dram_wdata), .i_dram_ctrl(i_dram_ctrl),
    .i_dram_le(i_dram_le), .i_dram_we_t(i_dram_we_t),
    .o_dram_odata(o_dram_odata), .o_dram_busy(o_dram_busy), .o_dram_err(o_dram_err),
    .mem_addr(mem_addr), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  assign mem_cmd_ready = ready_en;
  assign mem_rdata     = mem_word;
  assign mem_rvalid    = rv_q | inj_rv;

  // Memory responder: one rvalid the cycle after each accepted read.
  always @(posedge CLK) begin
    rv_q <= 1'b0;
    if (mem_cmd_valid) n_valid <= n_valid + 1;
    if (mem_cmd_valid && mem_cmd_ready) begin
      if (mem_we) begin
        n_wr    <= n_wr + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end else begin
        n_rd    <= n_rd + 1;
        rd_addr <= mem_addr;
        if (rv_en) rv_q <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request; stall > 0 holds cmd_ready low that many cycles and checks the command is held.
  task automatic do_req(input string name, input bit st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] ct, input logic [31:0] word, input int stall);
    mem_word = word;
    rd0 = n_rd; wr0 = n_wr; v0 = n_valid;
    ready_en = (stall == 0);
    i_dram_addr = a; i_dram_wdata = wd; i_dram_ctrl = ct;
    if (st) i_dram_we_t = 1'b1; else i_dram_le = 1'b1;
    @(posedge CLK); #1;
    i_dram_le = 1'b0; i_dram_we_t = 1'b0;
    lat = 1;
    for (int k = 0; k < stall; k++) begin
      check({name, "_hold_valid"}, 32'(mem_cmd_valid), 32'd1);
      check({name, "_hold_we"}, 32'(mem_we), 32'd1);
      check({name, "_hold_addr"}, mem_addr, {a[31:2], 2'b00});
      check({name, "_hold_wdata"}, mem_wdata, wd);
      @(posedge CLK); #1;
      lat++;
    end
    ready_en = 1'b1;
    while (o_dram_busy && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({name, "_busy_bound"}, 32'(lat < 200), 32'd1);
    $display("txn %-6s addr=%h wdata=%h ctrl=%b -> odata=%h err=%b lat=%0d rd=%0d wr=%0d",
             name, a, wd, ct, o_dram_odata, o_dram_err, lat, n_rd - rd0, n_wr - wr0);
  endtask

  initial begin
    RST = 1'b1;
    i_dram_addr = '0; i_dram_wdata = '0; i_dram_ctrl = '0;
    i_dram_le = 1'b0; i_dram_we_t = 1'b0;
    ready_en = 1'b1; rv_en = 1'b1; inj_rv = 1'b0; mem_word = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_odata", o_dram_odata, 32'h0);
    check("rst_busy", 32'(o_dram_busy), 32'd0);
    check("rst_err", 32'(o_dram_err), 32'd0);
    check("rst_cmd_valid", 32'(mem_cmd_valid), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;

    do_req("LB", 1'b0, 32'h8000_0003, 32'h0, 3'b000, 32'h8011_2233, 0);
    check("lb_odata", o_dram_odata, 32'hFFFF_FF80);
    check("lb_lat", lat, 3);
    check("lb_reads", n_rd - rd0, 1);
    check("lb_writes", n_wr - wr0, 0);
    check("lb_rd_addr", rd_addr, 32'h8000_0000);
    check("lb_err", 32'(o_dram_err), 32'd0);

    do_req("LHU", 1'b0, 32'h8000_0002, 32'h0, 3'b101, 32'h8001_0000, 0);
    check("lhu_odata", o_dram_odata, 32'h0000_8001);
    do_req("LH", 1'b0, 32'h8000_0002, 32'h0, 3'b001, 32'h8001_0000, 0);
    check("lh_odata", o_dram_odata, 32'hFFFF_8001);

    do_req("SB", 1'b1, 32'h8000_0001, 32'h0000_00AB, 3'b000, 32'h1122_3344, 0);
    check("sb_reads", n_rd - rd0, 1);
    check("sb_writes", n_wr - wr0, 1);
    check("sb_wr_addr", wr_addr, 32'h8000_0000);
    check("sb_wr_data", wr_data, 32'h1122_AB44);
    check("sb_lat", lat, 4);

    do_req("SH", 1'b1, 32'h8000_0006, 32'hFFFF_5566, 3'b001, 32'hAABB_CCDD, 0);
    check("sh_wr_addr", wr_addr, 32'h8000_0004);
    check("sh_wr_data", wr_data, 32'h5566_CCDD);

    do_req("SW", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0, 0);
    check("sw_reads", n_rd - rd0, 0);
    check("sw_writes", n_wr - wr0, 1);
    check("sw_wr_addr", wr_addr, 32'h8000_0010);
    check("sw_wr_data", wr_data, 32'hDEAD_BEEF);
    check("sw_lat", lat, 2);

    do_req("SWst", 1'b1, 32'h8000_0020, 32'h1234_5678, 3'b010, 32'h0, 5);
    check("swst_lat", lat, 7);
    check("swst_writes", n_wr - wr0, 1);
    check("swst_wr_data", wr_data, 32'h1234_5678);

    do_req("LWmis", 1'b0, 32'h8000_0002, 32'h0, 3'b010, 32'h5555_5555, 0);
    check("mis_err", 32'(o_dram_err), 32'd1);
    check("mis_lat", lat, 2);
    check("mis_odata", o_dram_odata, 32'h0);
    check("mis_no_cmd", n_valid - v0, 0);

    do_req("LW", 1'b0, 32'h8000_0004, 32'h0, 3'b010, 32'h0102_0304, 0);
    check("lw_err_clr", 32'(o_dram_err), 32'd0);
    check("lw_odata", o_dram_odata, 32'h0102_0304);

    rv_en = 1'b0;
    do_req("LWto", 1'b0, 32'h8000_0008, 32'h0, 3'b010, 32'h7777_7777, 0);
    check("to_err", 32'(o_dram_err), 32'd1);
    check("to_lat", lat, 10);
    check("to_odata", o_dram_odata, 32'h0102_0304);
    check("to_cmd_valid", 32'(mem_cmd_valid), 32'd0);

    // Reset while waiting for read data, then a stray rvalid.
    mem_word = 32'h9999_9999;
    i_dram_addr = 32'h8000_000C; i_dram_ctrl = 3'b010; i_dram_le = 1'b1;
    @(posedge CLK); #1;
    i_dram_le = 1'b0;
    @(posedge CLK); #1;
    check("rstw_busy_before", 32'(o_dram_busy), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rstw_busy", 32'(o_dram_busy), 32'd0);
    check("rstw_cmd_valid", 32'(mem_cmd_valid), 32'd0);
    check("rstw_err", 32'(o_dram_err), 32'd0);
    inj_rv = 1'b1;
    @(posedge CLK); #1;
    inj_rv = 1'b0;
    @(posedge CLK); #1;
    check("late_rv_busy", 32'(o_dram_busy), 32'd0);
    check("late_rv_odata", o_dram_odata, 32'h0);
    $display("txn RSTmid addr=%h -> busy=%b odata=%h", 32'h8000_000C, o_dram_busy, o_dram_odata);
    rv_en = 1'b1;

    do_req("LBU", 1'b0, 32'h8000_0000, 32'h0, 3'b100, 32'h0000_00F0, 0);
    check("lbu_odata", o_dram_odata, 32'h0000_00F0);
    check("lbu_lat", lat, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    n_rd = 0; n_wr = 0; n_valid = 0; rv_q = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
  end

endmodule
